// File: rtl/rsp_s2_prep_cmult_sat.sv
// rsp_s2_prep_cmult_sat: 5-stage multi-lane (x-u)*w / (x-u)*conj(w) with round, saturate, sticky sat flag
module rsp_s2_prep_cmult_sat #(
    parameter int SAMPLE_WIDTH = 32,
    parameter int TWIDDLE_WIDTH = 50,
    parameter int NUM_CH = 4,
    parameter int FRAC = TWIDDLE_WIDTH / 2 - 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [1:0]                        i_mode,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0]    i_x_data,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0]    i_u,
    input  logic [NUM_CH*TWIDDLE_WIDTH-1:0]   i_w,
    input  logic                              i_valid,
    output logic                              o_ready,
    output logic [NUM_CH*SAMPLE_WIDTH-1:0]    o_y,
    output logic                              o_valid,
    input  logic                              i_ready,
    input  logic                              i_clr_sat,
    output logic                              o_sat
);
    localparam int H = SAMPLE_WIDTH / 2;
    localparam int T = TWIDDLE_WIDTH / 2;
    localparam int P = H + T + 2;
    localparam int S = P + 1;
    localparam int Q = S + 1 - FRAC;
    localparam logic signed [S:0] RND = (S + 1)'(1) << (FRAC - 1);

    logic                            en;
    logic [4:0]                      v;
    logic [4:0][1:0]                 m;
    logic [NUM_CH*SAMPLE_WIDTH-1:0]  y_nxt;
    logic [2*NUM_CH-1:0]             sat_nxt;

    // Returns {overflow, clamped H-bit value}
    function automatic logic [H:0] sat_q(input logic [Q-1:0] q);
        logic ovf;
        ovf = !(&q[Q-1:H-1] || ~|q[Q-1:H-1]);
        return {ovf, ovf ? {q[Q-1], {(H-1){~q[Q-1]}}} : q[H-1:0]};
    endfunction

    assign en = !o_valid || i_ready;
    assign o_ready = en;

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            o_valid <= 1'b0;
            o_y <= '0;
            o_sat <= 1'b0;
        end else begin
            if (en) begin
                v <= {v[3:0], i_valid};
                o_valid <= v[4];
            end
            if (en && v[4]) o_y <= y_nxt;
            if (en && v[4] && |sat_nxt) o_sat <= 1'b1;
            else if (i_clr_sat) o_sat <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (en) m <= {m[3:0], i_mode};
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        logic signed [H-1:0] xr, xi, ur, ui, xr1, xi1;
        logic signed [T-1:0] wr, wi, wr1, wi1, wr2;
        logic signed [H:0]   er1, ei1, er2, ei2;
        logic signed [T:0]   wi2;
        logic signed [P-1:0] pa, pb, pc, pd;
        logic signed [S-1:0] re4, im4;
        logic [Q-1:0]        qr5, qi5;
        logic [H-1:0]        ar2, ai2, ar3, ai3, ar4, ai4, ar5, ai5;
        logic [1:0]          as2, as3, as4, as5;
        logic [H:0]          er_s, ei_s, qr_s, qi_s;
        assign xr = i_x_data[g*SAMPLE_WIDTH +: H];
        assign xi = i_x_data[g*SAMPLE_WIDTH+H +: H];
        assign ur = i_u[g*SAMPLE_WIDTH +: H];
        assign ui = i_u[g*SAMPLE_WIDTH+H +: H];
        assign wr = i_w[g*TWIDDLE_WIDTH +: T];
        assign wi = i_w[g*TWIDDLE_WIDTH+T +: T];
        assign er_s = sat_q(Q'(er1));
        assign ei_s = sat_q(Q'(ei1));
        assign qr_s = sat_q(qr5);
        assign qi_s = sat_q(qi5);
        // Conjugation folds into the twiddle: negating wi turns mode 0 equations into mode 1
        always_ff @(posedge clk) begin
            if (en) begin
                er1 <= (H + 1)'(xr) - (H + 1)'(ur);
                ei1 <= (H + 1)'(xi) - (H + 1)'(ui);
                xr1 <= xr;
                xi1 <= xi;
                wr1 <= wr;
                wi1 <= wi;
                er2 <= er1;
                ei2 <= ei1;
                wr2 <= wr1;
                wi2 <= m[0] == 2'd1 ? -((T + 1)'(wi1)) : (T + 1)'(wi1);
                ar2 <= m[0] == 2'd2 ? xr1 : er_s[H-1:0];
                ai2 <= m[0] == 2'd2 ? xi1 : ei_s[H-1:0];
                as2 <= m[0] == 2'd3 ? {ei_s[H], er_s[H]} : 2'b00;
                pa <= P'(er2) * P'(wr2);
                pb <= P'(ei2) * P'(wi2);
                pc <= P'(er2) * P'(wi2);
                pd <= P'(ei2) * P'(wr2);
                ar3 <= ar2;
                ai3 <= ai2;
                as3 <= as2;
                re4 <= S'(pa) - S'(pb);
                im4 <= S'(pc) + S'(pd);
                ar4 <= ar3;
                ai4 <= ai3;
                as4 <= as3;
                qr5 <= Q'(((S + 1)'(re4) + RND) >>> FRAC);
                qi5 <= Q'(((S + 1)'(im4) + RND) >>> FRAC);
                ar5 <= ar4;
                ai5 <= ai4;
                as5 <= as4;
            end
        end
        assign y_nxt[g*SAMPLE_WIDTH +: SAMPLE_WIDTH] = m[4][1] ? {ai5, ar5} : {qi_s[H-1:0], qr_s[H-1:0]};
        assign sat_nxt[2*g +: 2] = m[4][1] ? as5 : {qi_s[H], qr_s[H]};
    end
endmodule

// File: doc/rsp_s2_prep_cmult_sat.md
# rsp_s2_prep_cmult_sat

Multi-lane, pipelined complex multiplier for RSP stage-2 preprocessing. Computes y = (x − u) · w (or · conj(w)) per lane, rounds, and saturates. Also provides subtract-only and bypass modes. Per-beat mode and twiddle are carried with the data, and a valid/ready handshake with full-pipeline stall lets it sit between the stage-2 input buffer and the downstream FFT feeder.

## Interface
Parameters:
- SAMPLE_WIDTH, 32, per-lane complex sample width {imag, real}, each SAMPLE_WIDTH/2 signed
- TWIDDLE_WIDTH, 50, per-lane twiddle width {imag, real}, each TWIDDLE_WIDTH/2 signed
- NUM_CH, 4, number of parallel lanes
- FRAC, TWIDDLE_WIDTH/2-2, twiddle fractional bits; product is shifted right by FRAC

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; one clock, synchronous and active-high
- i_mode  in  2  0: (x−u)·w; 1: (x−u)·conj(w); 2: bypass x; 3: x−u only
- i_x_data  in  NUM_CH*SAMPLE_WIDTH  lane k at [k*SAMPLE_WIDTH +: SAMPLE_WIDTH], {imag, real}
- i_u  in  NUM_CH*SAMPLE_WIDTH  per-lane offset, same packing
- i_w  in  NUM_CH*TWIDDLE_WIDTH  per-lane twiddle {imag, real}
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat this cycle
- o_y  out  NUM_CH*SAMPLE_WIDTH  result, same packing as i_x_data
- o_valid  out  1  o_y valid
- i_ready  in  1  downstream accepts o_y
- i_clr_sat  in  1  clears o_sat
- o_sat  out  1  sticky: any lane component saturated since last clear or reset

## Operation
- A beat is accepted when i_valid && o_ready. i_mode, i_x_data, i_u and i_w are all sampled on that edge and travel with the beat.
  - No held or latched twiddle state.
  - A mode change takes effect on the very next beat, with no flush.
- Pipeline enable: en = !o_valid || i_ready. o_ready = en (combinational).
  - When en = 0, every stage, including valid bits, holds.
- Stages:
  - S1: e = x − u per component, SAMPLE_WIDTH/2+1 bits, exact.
  - S2: pre-adds and register w.
  - S3: products.
  - S4: post-add.
  - S5: round, saturate, and register into o_y/o_valid.
- Mode 0:
  - re = er·wr − ei·wi
  - im = er·wi + ei·wr
- Mode 1:
  - re = er·wr + ei·wi
  - im = ei·wr − er·wi
- Modes 0 and 1 use full-precision intermediates. Either a 3-multiplier or a 4-multiplier structure is allowed; the result must be bit-exact.
- Rounding: r = (p + 2^(FRAC−1)) >>> FRAC, i.e. round half toward +∞.
- Saturation: clamp to [−2^(SAMPLE_WIDTH/2−1), 2^(SAMPLE_WIDTH/2−1)−1].
- Mode 3: the e components are saturated to SAMPLE_WIDTH/2 with no rounding.
- Mode 2: x is passed through unchanged. It never saturates.
- Every mode has the same latency. Output order always equals input order.
- o_sat is set in the cycle a saturated beat is loaded into o_y.
  - i_clr_sat clears o_sat.
  - If a clear and a new saturation event coincide, the set wins.

## Timing
- Reset values:
  - o_valid = 0, o_y = 0, o_sat = 0.
  - All internal valid bits = 0.
  - o_ready = 1 in the first cycle after reset.
- Latency: 5 cycles. A beat accepted at edge n appears on o_y/o_valid after edge n+5, provided en stayed 1.
- Throughput: 1 beat/cycle while i_ready = 1.
- Stall: while o_valid && !i_ready, o_y is stable and no input is accepted.
  - When i_ready rises, the pipeline resumes with no loss and no duplication.
- Bubbles: while o_valid = 0, the pipeline advances even if i_ready = 0. It fills without waiting on downstream.
- rst asserted mid-stream:
  - All in-flight beats are discarded.
  - o_valid = 0 and o_sat = 0 on the next cycle.
  - rst has priority over stall and i_clr_sat.

## Test plan
- Identity: mode 0, x = (re 1000, im −2000), u = 0, w = (2^23, 0), all lanes → o_y = (1000, −2000) exactly 5 cycles later. o_sat = 0.
- Rotation and conj: x = (1000, −2000), w = (0, 2^23).
  - Mode 0 → (re 2000, im 1000).
  - Mode 1 → (re −2000, im −1000).
  - The two beats are issued back-to-back with alternating modes.
- Rounding and subtract: w = (2^22, 0), u = 0.
  - x.re = 3 → 2.
  - x.re = −3 → −1.
  - x.re = 1 → 1.
- Saturation: mode 0, x.re = 32767, u.re = −32768, w = (2^23, 0) → re = 32767 and o_sat = 1.
  - Mode 3 with the same x and u → 32767.
  - A negative case → −32768.
  - i_clr_sat → o_sat = 0.
- Backpressure: stream 20 beats with incrementing x, mode 2, and i_ready low for 3 cycles at random points → all 20 delivered in order, unchanged. o_y stays stable during each stall.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight → o_valid = 0 next cycle and none of the 3 beats emerges. The next accepted beat appears after 5 cycles.
